// File: rtl/cpu_param_pkg.sv
// Shared CPU defaults: fetch vectors, instruction-memory window and the
// encoding of the pending-redirect FSM used by the PC generator.
package cpu_param_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEF   = 32'h0000_4000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PEND_EXC  = 2'd1,
    PEND_ERET = 2'd2
  } redir_state_e;

endpackage : cpu_param_pkg

// File: rtl/pc_range_check.sv
// Fetch address-error detector: flags a PC that is misaligned or lies
// outside the instruction-memory window [IM_BASE, IM_BASE+IM_BYTES).
module pc_range_check
  import cpu_param_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(IM_BASE_DEF),
  parameter logic [WIDTH-1:0] IM_BYTES = WIDTH'(IM_BYTES_DEF)
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic             adel_o
);

  // One extra bit so that IM_BASE+IM_BYTES cannot wrap around.
  localparam logic [WIDTH:0] LO_BOUND = {1'b0, IM_BASE};
  localparam logic [WIDTH:0] HI_BOUND = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  logic [WIDTH:0] pc_ext;

  assign pc_ext = {1'b0, pc_i};
  assign adel_o = (pc_i[1:0] != 2'b00) | (pc_ext < LO_BOUND) | (pc_ext >= HI_BOUND);

endmodule : pc_range_check

// File: rtl/pc_gen.sv
// Fetch-address generator: owns the PC, picks the next fetch address from
// reset/exception/eret/stall/jump/branch, and optionally defers CP0 redirects.
module pc_gen
  import cpu_param_pkg::*;
#(
  parameter int unsigned      WIDTH               = 32,
  parameter logic [WIDTH-1:0] RESET_PC            = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR          = WIDTH'(EXC_VECTOR_DEF),
  parameter logic [WIDTH-1:0] IM_BASE             = WIDTH'(IM_BASE_DEF),
  parameter logic [WIDTH-1:0] IM_BYTES            = WIDTH'(IM_BYTES_DEF),
  parameter bit               EXC_OVERRIDES_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_4,
  output logic [WIDTH-1:0] next_pc,
  output logic             fetch_adel,
  output logic             redirect_pending
);

  localparam bit DEFER = !EXC_OVERRIDES_STALL;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  redir_state_e     state_q, state_d;

  logic redir_ok;
  logic take_exc;
  logic take_eret;

  // In deferring mode CP0 redirects only take effect on an unstalled cycle;
  // a held exception also beats a fresh eret.
  assign redir_ok  = !DEFER || !stall;
  assign take_exc  = redir_ok && exc_req;
  assign take_eret = redir_ok && eret_req && !exc_req && (state_q != PEND_EXC);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      state_q       <= RUN;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state logic for the pending-redirect FSM
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    if (take_exc || take_eret) begin
      state_d = RUN;
    end else if (stall) begin
      if (DEFER) begin
        unique case (state_q)
          RUN: begin
            if (exc_req) begin
              state_d = PEND_EXC;
            end else if (eret_req) begin
              state_d       = PEND_ERET;
              pend_target_d = epc;
            end
          end
          PEND_ERET: begin
            if (exc_req) state_d = PEND_EXC;
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      state_d = RUN;
    end
  end

  // Output logic: next fetch address mux and status
  always_comb begin
    pc_d = pc_4;
    if (take_exc) begin
      pc_d = EXC_VECTOR;
    end else if (take_eret) begin
      pc_d = epc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (state_q == PEND_EXC) begin
      pc_d = EXC_VECTOR;
    end else if (state_q == PEND_ERET) begin
      pc_d = pend_target_q;
    end else if (jump) begin
      pc_d = jump_addr;
    end else if (branch) begin
      pc_d = branch_addr;
    end
  end

  assign pc               = pc_q;
  assign pc_4             = pc_q + WIDTH'(32'd4);
  assign next_pc          = reset ? RESET_PC : pc_d;
  assign redirect_pending = DEFER ? (state_q != RUN) : 1'b0;

  pc_range_check #(
    .WIDTH    (WIDTH),
    .IM_BASE  (IM_BASE),
    .IM_BYTES (IM_BYTES)
  ) u_range_check (
    .pc_i   (pc_q),
    .adel_o (fetch_adel)
  );

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance per redirect mode, driven by the
// same inputs, with hand-computed expected fetch addresses.
module tb_pc_gen;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         branch;
  logic [W-1:0] branch_addr;
  logic         jump;
  logic [W-1:0] jump_addr;
  logic         exc_req;
  logic         eret_req;
  logic [W-1:0] epc;

  logic [W-1:0] pc1, pc_4_1, next_pc1;
  logic         adel1, pend1;
  logic [W-1:0] pc0, pc_4_0, next_pc0;
  logic         adel0, pend0;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  pc_gen #(.WIDTH(W), .EXC_OVERRIDES_STALL(1'b1)) u_dut1 (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch           (branch),
    .branch_addr      (branch_addr),
    .jump             (jump),
    .jump_addr        (jump_addr),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc               (pc1),
    .pc_4             (pc_4_1),
    .next_pc          (next_pc1),
    .fetch_adel       (adel1),
    .redirect_pending (pend1)
  );

  pc_gen #(.WIDTH(W), .EXC_OVERRIDES_STALL(1'b0)) u_dut0 (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch           (branch),
    .branch_addr      (branch_addr),
    .jump             (jump),
    .jump_addr        (jump_addr),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .pc               (pc0),
    .pc_4             (pc_4_0),
    .next_pc          (next_pc0),
    .fetch_adel       (adel0),
    .redirect_pending (pend0)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall       = 1'b0;
    branch      = 1'b0;
    branch_addr = '0;
    jump        = 1'b0;
    jump_addr   = '0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    epc         = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("reset_pc1", pc1, 32'h3000);
    check("reset_pc0", pc0, 32'h3000);
    check("reset_pend0", {31'b0, pend0}, 32'h0);
    check("reset_adel", {31'b0, adel1}, 32'h0);
    check("reset_next_pc", next_pc1, 32'h3000);
    reset = 1'b0;

    // Free-running fetch
    exp_q.push_back(32'h3004);
    exp_q.push_back(32'h3008);
    exp_q.push_back(32'h300C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_pc", pc1, exp_q.pop_front());
    end
    check("seq_pc_4", pc_4_1, 32'h3010);
    check("seq_adel", {31'b0, adel1}, 32'h0);

    // Jump beats branch, then stall holds
    jump = 1'b1; jump_addr = 32'h3100;
    branch = 1'b1; branch_addr = 32'h3200;
    #1;
    check("jmp_next_pc", next_pc1, 32'h3100);
    tick();
    check("jmp_pc", pc1, 32'h3100);
    jump = 1'b0; branch = 1'b0;
    stall = 1'b1;
    tick();
    check("stall_pc_a", pc1, 32'h3100);
    tick();
    check("stall_pc_b", pc1, 32'h3100);

    // Exception during stall: mode 1 takes it, mode 0 defers it
    exc_req = 1'b1;
    #1;
    check("m1_exc_next_pc", next_pc1, 32'h4180);
    check("m0_exc_next_pc", next_pc0, 32'h3100);
    tick();
    exc_req = 1'b0;
    check("m1_exc_pc", pc1, 32'h4180);
    check("m1_pend", {31'b0, pend1}, 32'h0);
    check("m0_hold_pc", pc0, 32'h3100);
    check("m0_pend", {31'b0, pend0}, 32'h1);
    tick();
    check("m0_pend_still", {31'b0, pend0}, 32'h1);
    stall = 1'b0;
    tick();
    check("m0_exc_pc", pc0, 32'h4180);
    check("m0_pend_clr", {31'b0, pend0}, 32'h0);

    // Mode 0: eret held, then exception overrides it; branch/jump ignored
    do_reset();
    stall = 1'b1; eret_req = 1'b1; epc = 32'h3040;
    tick();
    eret_req = 1'b0;
    check("t4_pend_a", {31'b0, pend0}, 32'h1);
    check("t4_hold_a", pc0, 32'h3000);
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    check("t4_pend_b", {31'b0, pend0}, 32'h1);
    check("t4_hold_b", pc0, 32'h3000);
    stall = 1'b0;
    jump = 1'b1; jump_addr = 32'h3100;
    branch = 1'b1; branch_addr = 32'h3200;
    #1;
    check("t4_next_pc", next_pc0, 32'h4180);
    tick();
    jump = 1'b0; branch = 1'b0;
    check("t4_pc", pc0, 32'h4180);
    check("t4_pend_clr", {31'b0, pend0}, 32'h0);
    tick();
    check("t4_after", pc0, 32'h4184);

    // Mode 0: captured epc is used, not the later value
    do_reset();
    stall = 1'b1; eret_req = 1'b1; epc = 32'h3040;
    tick();
    eret_req = 1'b0; epc = 32'h5000;
    tick();
    check("t5_pend", {31'b0, pend0}, 32'h1);
    stall = 1'b0;
    tick();
    check("t5_pc", pc0, 32'h3040);
    check("t5_pend_clr", {31'b0, pend0}, 32'h0);

    // Exception and eret together unstalled: exception wins
    eret_req = 1'b1; exc_req = 1'b1; epc = 32'h3400;
    tick();
    eret_req = 1'b0; exc_req = 1'b0;
    check("both_pc0", pc0, 32'h4180);
    check("both_pc1", pc1, 32'h4180);

    // Address check boundaries and pc_4 wrap
    do_reset();
    jump = 1'b1; jump_addr = 32'h3002;
    tick();
    check("adel_misalign", {31'b0, adel1}, 32'h1);
    jump_addr = 32'h7000;
    tick();
    check("adel_high", {31'b0, adel1}, 32'h1);
    jump_addr = 32'h6FFC;
    tick();
    check("adel_top_ok", {31'b0, adel1}, 32'h0);
    check("top_pc_4", pc_4_1, 32'h7000);
    jump_addr = 32'h2FFC;
    tick();
    check("adel_low", {31'b0, adel0}, 32'h1);
    jump_addr = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    check("wrap_pc_4", pc_4_1, 32'h0);
    check("wrap_adel", {31'b0, adel1}, 32'h1);
    tick();
    check("wrap_pc", pc1, 32'h0);

    // Reset while an exception is pending discards it
    do_reset();
    stall = 1'b1; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    check("rst_pend_set", {31'b0, pend0}, 32'h1);
    reset = 1'b1;
    tick();
    check("rst_pend_pc", pc0, 32'h3000);
    check("rst_pend_clr", {31'b0, pend0}, 32'h0);
    reset = 1'b0; stall = 1'b0;
    tick();
    check("rst_discard", pc0, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_gen
